// File: rtl/vdp_linebuf_pkg.sv
// Shared definitions for the VDP double-buffered line memory: sequencer states
// and the default line geometry used by the controller and the buffer wrapper.
package vdp_linebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } lb_state_e;

    localparam int unsigned DEF_LINE_WIDTH = 720;
    localparam int unsigned DEF_ADDR_W     = 10;

endpackage

// File: rtl/vdp_linebuf_addr_cnt.sv
// Saturating pixel address counter: clear wins over increment, and the count
// never advances past the limit value.
module vdp_linebuf_addr_cnt #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] cnt
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vdp_linebuf_ctrl.sv
// Line buffer sequencer: fills one bank from the pixel source while the display
// drains the other, swapping banks on every LINE_START.
//
// Write handshake: a pixel transfers in any cycle where WR_VALID and WR_READY are
// both high; WR_READY does not depend on WR_VALID, and WE is exactly that transfer.
module vdp_linebuf_ctrl
    import vdp_linebuf_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              LINE_START,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic              RD_EN,
    output logic              EVENODD,
    output logic              WE,
    output logic [ADDR_W-1:0] XPOSITIONW,
    output logic [ADDR_W-1:0] XPOSITIONR,
    output logic              RD_VALID,
    output logic              LINE_DONE,
    output logic              OVERRUN,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_WIDTH - 1);

    lb_state_e state_q, state_d;
    logic      evenodd_q, evenodd_d;
    logic      rd_bank_ok_q, rd_bank_ok_d;
    logic      rd_en_q, rd_en_d;
    logic      line_done_q, line_done_d;
    logic      overrun_q, overrun_d;

    logic              wr_ready;
    logic              we;
    logic              line_complete;
    logic [ADDR_W-1:0] xpos_w;
    logic [ADDR_W-1:0] xpos_r;

    assign wr_ready      = (state_q == ST_FILL);
    assign we            = WR_VALID & wr_ready;
    assign line_complete = we && (xpos_w == LAST_ADDR);

    // A same-cycle LINE_START still lets this cycle's write land at the old
    // address; the clear only takes effect on the following edge.
    vdp_linebuf_addr_cnt #(.ADDR_W(ADDR_W)) u_wr_addr (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clr   (LINE_START),
        .inc   (we),
        .limit (LAST_ADDR),
        .cnt   (xpos_w)
    );

    vdp_linebuf_addr_cnt #(.ADDR_W(ADDR_W)) u_rd_addr (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clr   (LINE_START),
        .inc   (RD_EN),
        .limit (LAST_ADDR),
        .cnt   (xpos_r)
    );

    always_comb begin
        state_d      = state_q;
        evenodd_d    = evenodd_q;
        rd_bank_ok_d = rd_bank_ok_q;
        overrun_d    = overrun_q;
        rd_en_d      = RD_EN;
        line_done_d  = line_complete;

        if (LINE_START) begin
            state_d      = ST_FILL;
            evenodd_d    = ~evenodd_q;
            rd_bank_ok_d = (state_q == ST_FULL) || line_complete;
            if ((state_q == ST_FILL) && !line_complete) begin
                overrun_d = 1'b1;
            end
        end else if (line_complete) begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            evenodd_q    <= 1'b0;
            rd_bank_ok_q <= 1'b0;
            rd_en_q      <= 1'b0;
            line_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            evenodd_q    <= evenodd_d;
            rd_bank_ok_q <= rd_bank_ok_d;
            rd_en_q      <= rd_en_d;
            line_done_q  <= line_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // The buffer RAM reads are registered, so validity trails RD_EN by one cycle.
    assign RD_VALID   = rd_en_q & rd_bank_ok_q;
    assign WR_READY   = wr_ready;
    assign WE         = we;
    assign EVENODD    = evenodd_q;
    assign XPOSITIONW = xpos_w;
    assign XPOSITIONR = xpos_r;
    assign LINE_DONE  = line_done_q;
    assign OVERRUN    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vdp_linebuf_ctrl.sv
// Cycle table bench for vdp_linebuf_ctrl with an 8-pixel line: each row gives the
// inputs for one cycle and the outputs expected in that same cycle.
module tb_vdp_linebuf_ctrl;

    localparam int LW = 8;
    localparam int AW = 4;
    localparam int W  = 14;

    logic          CLK;
    logic          RESET_N;
    logic          LINE_START;
    logic          WR_VALID;
    logic          WR_READY;
    logic          RD_EN;
    logic          EVENODD;
    logic          WE;
    logic [AW-1:0] XPOSITIONW;
    logic [AW-1:0] XPOSITIONR;
    logic          RD_VALID;
    logic          LINE_DONE;
    logic          OVERRUN;
    logic [1:0]    dbg_state;

    vdp_linebuf_ctrl #(.LINE_WIDTH(LW), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .LINE_START (LINE_START),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .RD_EN      (RD_EN),
        .EVENODD    (EVENODD),
        .WE         (WE),
        .XPOSITIONW (XPOSITIONW),
        .XPOSITIONR (XPOSITIONR),
        .RD_VALID   (RD_VALID),
        .LINE_DONE  (LINE_DONE),
        .OVERRUN    (OVERRUN),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          rst_n;
        logic          ls;
        logic          wv;
        logic          re;
        logic          we;
        logic [AW-1:0] xw;
        logic          rdy;
        logic          eo;
        logic [AW-1:0] xr;
        logic          rdv;
        logic          done;
        logic          ovr;
        logic          chk_rdv;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    int           n_cmp;
    int           n_err;

    task automatic add(input logic r, input logic ls, input logic wv, input logic re,
                       input logic we, input logic [AW-1:0] xw, input logic rdy,
                       input logic eo, input logic [AW-1:0] xr, input logic rdv,
                       input logic done, input logic ovr, input logic crdv);
        vec_t v;
        v.rst_n = r;  v.ls = ls;   v.wv = wv;   v.re = re;
        v.we = we;    v.xw = xw;   v.rdy = rdy; v.eo = eo;
        v.xr = xr;    v.rdv = rdv; v.done = done; v.ovr = ovr;
        v.chk_rdv = crdv;
        vecs.push_back(v);
    endtask

    // driver: apply one row and record what the outputs must show this cycle
    task automatic drive_row(input vec_t v);
        @(negedge CLK);
        RESET_N    = v.rst_n;
        LINE_START = v.ls;
        WR_VALID   = v.wv;
        RD_EN      = v.re;
        exp_q.push_back({v.we, v.xw, v.rdy, v.eo, v.xr, v.rdv, v.done, v.ovr});
        msk_q.push_back({{(W-3){1'b1}}, v.chk_rdv, 2'b11});
    endtask

    // scoreboard: pop the expectation for the current cycle and compare
    task automatic check_row(input int idx);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        logic [W-1:0] msk;
        act = {WE, XPOSITIONW, WR_READY, EVENODD, XPOSITIONR, RD_VALID, LINE_DONE, OVERRUN};
        exp = exp_q.pop_front();
        msk = msk_q.pop_front();
        n_cmp++;
        if ((act & msk) !== (exp & msk)) begin
            n_err++;
            $display("FAIL row%0d {we,xw,rdy,eo,xr,rdv,done,ovr}: got %b_%h_%b_%b_%h_%b_%b_%b want %b_%h_%b_%b_%h_%b_%b_%b (rdv checked=%b)",
                     idx, act[13], act[12:9], act[8], act[7], act[6:3], act[2], act[1], act[0],
                     exp[13], exp[12:9], exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0], msk[2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        RESET_N    = 1'b0;
        LINE_START = 1'b0;
        WR_VALID   = 1'b0;
        RD_EN      = 1'b0;
        repeat (3) @(posedge CLK);

        // reset state, first LINE_START out of IDLE, first full line
        //   r  ls wv re   we xw rdy eo   xr rdv done ovr chk
        add(1, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1);
        add(1, 1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1);
        for (int k = 0; k < LW; k++)
            add(1, 0, 1, 0,   1, 4'(k), 1, 1,   0, 0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 7, 0, 1,   0, 0, 1, 0, 1);
        add(1, 0, 1, 0,   0, 7, 0, 1,   0, 0, 0, 0, 1);

        // second LINE_START swaps a complete line; 10 reads saturate at 7
        add(1, 1, 0, 0,   0, 7, 0, 1,   0, 0, 0, 0, 1);
        for (int j = 0; j < 10; j++)
            add(1, 0, 0, 1,   0, 0, 1, 0,   4'((j > 7) ? 7 : j), (j >= 1), 0, 0, (j <= 8));
        add(1, 0, 0, 0,   0, 0, 1, 0,   7, 0, 0, 0, 0);

        // LINE_START together with the 8th write: line completes, no overrun
        for (int k = 0; k < LW - 1; k++)
            add(1, 0, 1, 0,   1, 4'(k), 1, 0,   7, 0, 0, 0, 1);
        add(1, 1, 1, 0,   1, 7, 1, 0,   7, 0, 0, 0, 1);
        add(1, 0, 0, 1,   0, 0, 1, 1,   0, 0, 1, 0, 1);
        add(1, 0, 0, 1,   0, 0, 1, 1,   1, 1, 0, 0, 1);
        add(1, 0, 0, 1,   0, 0, 1, 1,   2, 1, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 1, 1,   3, 1, 0, 0, 1);

        // LINE_START after 5 writes: overrun, swapped line reads invalid
        for (int k = 0; k < 5; k++)
            add(1, 0, 1, 0,   1, 4'(k), 1, 1,   3, 0, 0, 0, 1);
        add(1, 1, 0, 0,   0, 5, 1, 1,   3, 0, 0, 0, 1);
        for (int j = 0; j < 4; j++)
            add(1, 0, 0, 1,   0, 0, 1, 0,   4'(j), 0, 0, 1, 1);
        add(1, 0, 0, 0,   0, 0, 1, 0,   4, 0, 0, 1, 1);

        // reset for one cycle at XPOSITIONW=4, then the next line reads invalid
        for (int k = 0; k < 4; k++)
            add(1, 0, 1, 0,   1, 4'(k), 1, 0,   4, 0, 0, 1, 1);
        add(0, 0, 1, 0,   1, 4, 1, 0,   4, 0, 0, 1, 1);
        add(1, 0, 1, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1);
        add(1, 1, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 1);
        for (int k = 0; k < LW; k++)
            add(1, 0, 1, 1,   1, 4'(k), 1, 1,   4'(k), 0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 7, 0, 1,   7, 0, 1, 0, 1);
        add(1, 1, 0, 0,   0, 7, 0, 1,   7, 0, 0, 0, 1);
        add(1, 0, 0, 1,   0, 0, 1, 0,   0, 0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 0, 1, 0,   1, 1, 0, 0, 1);

        // WR_VALID toggling: 8 writes in 15 cycles at contiguous addresses
        for (int i = 0; i < 15; i++)
            add(1, 0, (i % 2 == 0), 0,   (i % 2 == 0), 4'((i + 1) / 2), 1, 0,   1, 0, 0, 0, 1);
        add(1, 0, 0, 0,   0, 7, 0, 0,   1, 0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_row(vecs[i]);
            #1;
            check_row(i);
        end

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
